uart_rx_dma: RTL and testbench
==============================

# uart_rx_dma

Receive-side DMA stage that accepts bytes from the UART receiver and drives the RX port of the shared RAM address/data multiplexer: `rx_en`, `rx_ad` and `RX_data`. It writes a programmed-length block of received bytes into consecutive RAM addresses starting at a given base. The multiplexer registers address, data and write-enable, so this block holds each write for a fixed window to guarantee the RAM captures it. It also reports progress, completion and overrun to the control logic.

## Interface
Parameters:
- HOLD_CYC, 3: cycles `rx_en`, `rx_ad` and `RX_data` are held per byte (minimum 2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a transfer; ignored while `busy`=1.
- base_ad  in  15  first RAM address; sampled on `start`.
- length  in  15  number of bytes to store; sampled on `start`.
- abort  in  1  terminates the active transfer.
- rx_valid  in  1  one-cycle strobe: `rx_byte` is valid.
- rx_byte  in  8  received byte.
- rx_en  out  1  RX owns the RAM port (to multiplexer).
- rx_ad  out  15  RAM write address (to multiplexer).
- RX_data  out  8  RAM write data (to multiplexer).
- busy  out  1  transfer active.
- done  out  1  one-cycle pulse when the transfer completes or is aborted.
- overrun  out  1  sticky flag: a byte was dropped; cleared on `start`.
- count  out  15  bytes written so far in the current transfer.

## Operation
- States:
  - IDLE: waiting for `start`.
  - WAIT: waiting for a byte.
  - WRITE: driving a RAM write.
  - FIN: terminating the transfer.
- IDLE + `start`:
  - Load the address pointer with `base_ad` and the remaining count with `length`.
  - `count`←0, `overrun`←0, `busy`←1.
  - If `length`=0, go to FIN; otherwise go to WAIT.
- WAIT + `rx_valid`: latch `rx_byte` into `RX_data` and the pointer into `rx_ad`; set `rx_en`=1; go to WRITE.
- WRITE:
  - Hold `rx_en`, `rx_ad` and `RX_data` stable for exactly HOLD_CYC cycles.
  - On exit: `rx_en`←0, pointer+1, `count`+1, remaining−1.
  - If remaining is now 0, go to FIN.
  - Else, if the pending register is full, start the next write from it immediately.
  - Else go to WAIT.
- Pending register: one byte deep.
  - An `rx_valid` during WRITE fills it if it is empty.
  - An `rx_valid` during WRITE while it is full drops the byte and sets `overrun`.
- FIN: `done` high for one cycle, `busy`←0, go to IDLE. Pending data is discarded.
- Address arithmetic: the pointer is 15-bit and wraps from 0x7FFF to 0x0000; no error is raised.
- `abort` in WAIT or WRITE: go to FIN next cycle, clear `rx_en`, discard the pending byte. A write cut short this way is not counted.
- `abort` in IDLE is ignored. `abort` and `start` together in IDLE: `start` wins.
- `rx_valid` in IDLE or FIN is ignored; this does not set `overrun`.
- Simultaneous `rx_valid` with the last WRITE cycle: the byte goes to the pending register if it is empty.
- `RX_data` and `rx_ad` keep their last values when `rx_en`=0.

## Timing
- Reset values, asynchronous: state IDLE; `rx_en`=0, `rx_ad`=0, `RX_data`=0, `busy`=0, `done`=0, `overrun`=0, `count`=0, pending register empty.
- Reset mid-write: `rx_en` drops immediately (asynchronous); the partial write is not counted.
- `start` at cycle T: `busy`=1 from T+1.
- `rx_valid` in WAIT at cycle T:
  - `rx_en`, `rx_ad` and `RX_data` valid from T+1 through T+HOLD_CYC.
  - `rx_en`=0 and `count` incremented at T+HOLD_CYC+1.
- Back-to-back from the pending register: `rx_en` stays high across the boundary. `rx_ad` and `RX_data` change on the same edge as `count` increments.
- Last byte: `done` pulses the cycle after the final WRITE exit; `busy`=0 the cycle after that.
- `length`=0: `done` at T+2 after `start`.
- Sustained throughput: 1 byte per HOLD_CYC cycles.

## Test plan
- Basic transfer: `base_ad`=0x0100, `length`=3, bytes 0xA1/0xB2/0xC3 spaced 10 cycles apart.
  - Writes land at 0x0100–0x0102; `rx_en` is high 3 cycles per byte.
  - `done` pulses once; `count`=3; `overrun`=0.
- Wrap-around: `base_ad`=0x7FFE, `length`=4.
  - Addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Overrun: `length`=4, three `rx_valid` pulses in consecutive cycles.
  - Bytes 1–2 are written back-to-back; byte 3 is dropped; `overrun`=1.
  - `count`=2 and the transfer is still `busy`.
  - A later `start` clears `overrun`.
- Zero length: `start` with `length`=0.
  - No `rx_en` assertion; `done` at T+2; `count`=0.
- Abort mid-write: `abort` on the 2nd cycle of the 2nd byte of 5.
  - `rx_en` low next cycle; `count`=1; `done` pulses once; `busy`=0.
- Async reset mid-write: assert `rst` between clock edges while `rx_en`=1.
  - All outputs go to their reset values immediately.
  - `start` ignored during reset; normal operation after release.

Source files
------------

// File: rtl/uart_rx_dma.sv
// Receive-side DMA stage: stores a programmed-length block of UART bytes into
// consecutive RAM addresses through the RX port of the RAM multiplexer.
// Each write is held for HOLD_CYC cycles. A one-byte pending register absorbs
// a byte that arrives during a write. Progress, completion and overrun are
// reported to the control logic.
module uart_rx_dma #(
   parameter int HOLD_CYC = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [14:0] base_ad,
   input  logic [14:0] length,
   input  logic        abort,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        rx_en,
   output logic [14:0] rx_ad,
   output logic [7:0]  RX_data,
   output logic        busy,
   output logic        done,
   output logic        overrun,
   output logic [14:0] count
);

   localparam int HW = $clog2(HOLD_CYC);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      WRITE,
      FIN
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [HW-1:0] hold_cnt;
   logic [14:0] ptr;
   logic [14:0] remaining;
   logic        pend_valid;
   logic [7:0]  pend_byte;

   logic        accept_start;
   logic        launch;
   logic        write_exit;
   logic        chain;
   logic        drop;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the per-cycle control strobes used by the datapath;
   // a byte arriving on the last hold cycle chains straight into the next write
   always_comb begin
      state_next   = state;
      accept_start = 1'b0;
      launch       = 1'b0;
      write_exit   = 1'b0;
      chain        = 1'b0;
      drop         = 1'b0;
      case (state)
         IDLE: begin
            if (start && !busy) begin
               accept_start = 1'b1;
               state_next   = (length == 15'd0) ? FIN : WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               state_next = FIN;
            end else if (rx_valid) begin
               launch     = 1'b1;
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (abort) begin
               state_next = FIN;
            end else begin
               drop = rx_valid && pend_valid;
               if (hold_cnt == HOLD_LAST) begin
                  write_exit = 1'b1;
                  if (remaining == 15'd1) begin
                     state_next = FIN;
                  end else if (pend_valid || rx_valid) begin
                     chain      = 1'b1;
                     state_next = WRITE;
                  end else begin
                     state_next = WAIT;
                  end
               end
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Hold-window counter, restarted whenever a new write begins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (launch || chain) begin
         hold_cnt <= '0;
      end else if (state == WRITE) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   // Address pointer and remaining-byte count, advanced only by completed writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         remaining <= '0;
      end else if (accept_start) begin
         ptr       <= base_ad;
         remaining <= length;
      end else if (write_exit) begin
         ptr       <= ptr + 15'd1;
         remaining <= remaining - 15'd1;
      end
   end

   // One-byte pending buffer; emptied whenever the transfer leaves WRITE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_byte  <= '0;
      end else if (state != WRITE || abort || chain) begin
         pend_valid <= 1'b0;
      end else if (rx_valid && !pend_valid) begin
         pend_valid <= 1'b1;
         pend_byte  <= rx_byte;
      end
   end

   // RAM port drive; address and data keep their last value while rx_en is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_en   <= 1'b0;
         rx_ad   <= '0;
         RX_data <= '0;
      end else if (launch) begin
         rx_en   <= 1'b1;
         rx_ad   <= ptr;
         RX_data <= rx_byte;
      end else if (chain) begin
         rx_en   <= 1'b1;
         rx_ad   <= ptr + 15'd1;
         RX_data <= pend_valid ? pend_byte : rx_byte;
      end else if (write_exit || (state == WRITE && abort)) begin
         rx_en <= 1'b0;
      end
   end

   // Completed-byte counter, cleared when a transfer is launched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (accept_start) begin
         count <= '0;
      end else if (write_exit) begin
         count <= count + 15'd1;
      end
   end

   // Status: busy spans launch through the done pulse, overrun is sticky
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= (state == FIN);
         if (accept_start) begin
            busy <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end
         if (accept_start) begin
            overrun <= 1'b0;
         end else if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_dma.sv
// Testbench for uart_rx_dma: directed scenarios plus randomized transfers,
// compared every cycle against a transaction-level schedule of RAM writes.
module tb_uart_rx_dma;

   localparam int HOLD = 3;
   localparam int BIG  = 32'h3FFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [14:0] base_ad;
   logic [14:0] length;
   logic        abort;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        rx_en;
   logic [14:0] rx_ad;
   logic [7:0]  RX_data;
   logic        busy;
   logic        done;
   logic        overrun;
   logic [14:0] count;

   uart_rx_dma #(.HOLD_CYC(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base_ad  (base_ad),
      .length   (length),
      .abort    (abort),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_en    (rx_en),
      .rx_ad    (rx_ad),
      .RX_data  (RX_data),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun),
      .count    (count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // Transfer plan: stimulus and the write schedule derived from it
   logic [14:0] pbase;
   logic [14:0] plen;
   int          t0;
   int          ab_off;
   int          ab_drive;
   int          ab_cyc;
   int          fin;
   int          ov_cyc;
   int          nw;
   int          arr_t[$];
   logic [7:0]  arr_d[$];
   int          w_s[$];
   logic [7:0]  w_d[$];
   bit          active;
   bit          queued;
   logic [7:0]  qd;
   logic [14:0] prev_ad = '0;
   logic [7:0]  prev_data = '0;
   int          chk_lo = 1;
   int          chk_hi = 0;

   // Observations of the RAM port
   logic [14:0] ad_log[$];
   int          en_cycles = 0;
   int          done_pulses = 0;
   logic        en_d = 1'b0;
   logic [14:0] ad_d = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Close the current write window at its exit cycle
   function automatic void closeWindow();
      int e;
      e = w_s[nw-1] + HOLD;
      if (nw == int'(plen)) begin
         fin = e;
      end else if (queued) begin
         w_s.push_back(e);
         w_d.push_back(qd);
         nw++;
         queued = 1'b0;
      end else begin
         active = 1'b0;
      end
   endfunction

   // Each write window accepts at most one new byte, which starts the next
   // write when the window ends; any further byte in that window is lost
   function automatic void buildPlan();
      w_s.delete();
      w_d.delete();
      nw     = 0;
      active = 1'b0;
      queued = 1'b0;
      fin    = -1;
      ov_cyc = BIG;
      if (plen == 15'd0) begin
         fin = t0 + 1;
         return;
      end
      foreach (arr_t[k]) begin
         int t;
         t = arr_t[k];
         if (t < t0 + 1 || t >= ab_cyc || fin >= 0) continue;
         while (fin < 0 && active && t >= w_s[nw-1] + HOLD) closeWindow();
         if (fin >= 0) continue;
         if (!active) begin
            w_s.push_back(t + 1);
            w_d.push_back(arr_d[k]);
            nw++;
            active = 1'b1;
         end else if (!queued) begin
            queued = 1'b1;
            qd     = arr_d[k];
         end else if (ov_cyc == BIG) begin
            ov_cyc = t + 1;
         end
      end
      while (fin < 0 && active && w_s[nw-1] + HOLD - 1 < ab_cyc) closeWindow();
      if (fin < 0 && ab_cyc < BIG) fin = ab_cyc + 1;
   endfunction

   function automatic logic expEn(input int c);
      foreach (w_s[i]) begin
         if (c >= w_s[i] && c <= w_s[i] + HOLD - 1 && c <= ab_cyc) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int expCount(input int c);
      int n;
      n = 0;
      foreach (w_s[i]) begin
         if (w_s[i] + HOLD <= c && w_s[i] + HOLD - 1 < ab_cyc) n++;
      end
      return n;
   endfunction

   function automatic int expIdx(input int c);
      int idx;
      idx = -1;
      foreach (w_s[i]) begin
         if (w_s[i] <= c) idx = i;
      end
      return idx;
   endfunction

   // Per-cycle comparison of every output against the plan
   always @(negedge clk) begin : cmp
      int          wi;
      logic [14:0] ead;
      logic [7:0]  edat;
      if (cyc >= chk_lo && cyc <= chk_hi) begin
         wi = expIdx(cyc);
         if (wi >= 0) begin
            ead  = pbase + 15'(wi);
            edat = w_d[wi];
         end else begin
            ead  = prev_ad;
            edat = prev_data;
         end
         checkOutput("rx_en",   32'(rx_en),   32'(expEn(cyc)));
         checkOutput("rx_ad",   32'(rx_ad),   32'(ead));
         checkOutput("RX_data", 32'(RX_data), 32'(edat));
         checkOutput("busy",    32'(busy),    32'(cyc <= fin + 1));
         checkOutput("done",    32'(done),    32'(cyc == fin + 1));
         checkOutput("overrun", 32'(overrun), 32'(cyc >= ov_cyc));
         checkOutput("count",   32'(count),   32'(expCount(cyc)));
      end
   end

   // Log each distinct write address and count rx_en and done cycles
   always @(negedge clk) begin
      if (rx_en && (!en_d || rx_ad != ad_d)) ad_log.push_back(rx_ad);
      if (rx_en) en_cycles++;
      if (done) done_pulses++;
      en_d <= rx_en;
      ad_d <= rx_ad;
   end

   // Run one planned transfer; arrival and abort offsets are relative to start
   task automatic applyStimulus(input bit want_xs);
      int xs_cyc;
      int last_t;
      int stop_c;
      ad_log.delete();
      en_cycles   = 0;
      done_pulses = 0;
      @(posedge clk);
      #1;
      t0 = cyc;
      foreach (arr_t[k]) arr_t[k] = arr_t[k] + t0;
      ab_drive = (ab_off < 0) ? -1 : t0 + ab_off;
      ab_cyc   = (ab_off <= 0) ? BIG : t0 + ab_off;
      buildPlan();
      if (fin < 0) begin
         last_t = t0;
         foreach (arr_t[k]) if (arr_t[k] > last_t) last_t = arr_t[k];
         ab_drive = last_t + int'($urandom_range(1, 4));
         ab_cyc   = ab_drive;
         buildPlan();
      end
      xs_cyc = want_xs ? t0 + 1 + int'($urandom_range(0, fin - t0)) : -1;
      chk_lo = t0 + 1;
      chk_hi = fin + 3;
      stop_c = fin + 3;
      for (int c = t0; c <= stop_c; c++) begin
         if (c != t0) begin
            @(posedge clk);
            #1;
         end
         start    = (c == t0) || (c == xs_cyc);
         base_ad  = (c == t0) ? pbase : 15'($urandom);
         length   = (c == t0) ? plen : 15'($urandom_range(0, 9));
         abort    = (c == ab_drive);
         rx_valid = 1'b0;
         rx_byte  = 8'($urandom);
         foreach (arr_t[k]) begin
            if (arr_t[k] == c) begin
               rx_valid = 1'b1;
               rx_byte  = arr_d[k];
            end
         end
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      abort    = 1'b0;
      if (nw > 0) begin
         prev_ad   = pbase + 15'(nw - 1);
         prev_data = w_d[nw-1];
      end
   endtask

   task automatic setPlan(input logic [14:0] b, input logic [14:0] l, input int ab);
      arr_t.delete();
      arr_d.delete();
      pbase  = b;
      plen   = l;
      ab_off = ab;
   endtask

   task automatic addByte(input int t, input logic [7:0] d);
      arr_t.push_back(t);
      arr_d.push_back(d);
   endtask

   // Async reset in the middle of a write, start ignored while held
   task automatic resetMidWrite();
      chk_hi = 0;
      @(posedge clk);
      #1;
      start    = 1'b1;
      base_ad  = 15'h1234;
      length   = 15'd3;
      @(posedge clk);
      #1;
      start    = 1'b0;
      rx_valid = 1'b1;
      rx_byte  = 8'h5A;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      checkOutput("rst_pre_en", 32'(rx_en), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_rx_en",   32'(rx_en),   32'd0);
      checkOutput("rst_rx_ad",   32'(rx_ad),   32'd0);
      checkOutput("rst_RX_data", 32'(RX_data), 32'd0);
      checkOutput("rst_busy",    32'(busy),    32'd0);
      checkOutput("rst_done",    32'(done),    32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      checkOutput("rst_count",   32'(count),   32'd0);
      start   = 1'b1;
      base_ad = 15'h0042;
      length  = 15'd2;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("rst_start_ignored", 32'(busy), 32'd0);
      start = 1'b0;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_release_busy", 32'(busy),  32'd0);
      checkOutput("rst_release_en",   32'(rx_en), 32'd0);
      prev_ad   = '0;
      prev_data = '0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      base_ad  = '0;
      length   = '0;
      abort    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rx_en",   32'(rx_en),   32'd0);
      checkOutput("reset_rx_ad",   32'(rx_ad),   32'd0);
      checkOutput("reset_RX_data", 32'(RX_data), 32'd0);
      checkOutput("reset_busy",    32'(busy),    32'd0);
      checkOutput("reset_done",    32'(done),    32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      checkOutput("reset_count",   32'(count),   32'd0);
      rst = 1'b0;

      $display("[TB] basic transfer");
      setPlan(15'h0100, 15'd3, -1);
      addByte(2, 8'hA1);
      addByte(12, 8'hB2);
      addByte(22, 8'hC3);
      applyStimulus(1'b0);
      checkOutput("basic_plan_done", 32'(fin + 1 - t0), 32'd27);
      checkOutput("basic_count",     32'(count),        32'd3);
      checkOutput("basic_overrun",   32'(overrun),      32'd0);
      checkOutput("basic_en_cycles", 32'(en_cycles),    32'd9);
      checkOutput("basic_done_once", 32'(done_pulses),  32'd1);
      checkOutput("basic_writes",    32'(ad_log.size()), 32'd3);
      if (ad_log.size() == 3) begin
         checkOutput("basic_ad0", 32'(ad_log[0]), 32'h0100);
         checkOutput("basic_ad1", 32'(ad_log[1]), 32'h0101);
         checkOutput("basic_ad2", 32'(ad_log[2]), 32'h0102);
      end

      $display("[TB] wrap-around");
      setPlan(15'h7FFE, 15'd4, -1);
      addByte(1, 8'h11);
      addByte(6, 8'h22);
      addByte(11, 8'h33);
      addByte(16, 8'h44);
      applyStimulus(1'b0);
      checkOutput("wrap_writes", 32'(ad_log.size()), 32'd4);
      if (ad_log.size() == 4) begin
         checkOutput("wrap_ad0", 32'(ad_log[0]), 32'h7FFE);
         checkOutput("wrap_ad1", 32'(ad_log[1]), 32'h7FFF);
         checkOutput("wrap_ad2", 32'(ad_log[2]), 32'h0000);
         checkOutput("wrap_ad3", 32'(ad_log[3]), 32'h0001);
      end

      $display("[TB] overrun");
      setPlan(15'h0200, 15'd4, 12);
      addByte(1, 8'h01);
      addByte(2, 8'h02);
      addByte(3, 8'h03);
      applyStimulus(1'b0);
      checkOutput("ovr_plan_cycle", 32'(ov_cyc - t0), 32'd4);
      checkOutput("ovr_plan_nw",    32'(nw),          32'd2);
      checkOutput("ovr_count",      32'(count),       32'd2);
      checkOutput("ovr_sticky",     32'(overrun),     32'd1);

      $display("[TB] zero length");
      setPlan(15'h0300, 15'd0, -1);
      addByte(1, 8'hEE);
      addByte(2, 8'hEF);
      applyStimulus(1'b0);
      checkOutput("zero_plan_done", 32'(fin + 1 - t0),  32'd2);
      checkOutput("zero_no_write",  32'(ad_log.size()), 32'd0);
      checkOutput("zero_count",     32'(count),         32'd0);
      checkOutput("zero_ovr_clear", 32'(overrun),       32'd0);

      $display("[TB] abort mid-write");
      setPlan(15'h0400, 15'd5, 8);
      addByte(1, 8'h55);
      addByte(6, 8'h66);
      applyStimulus(1'b0);
      checkOutput("abort_plan_fin", 32'(fin - t0),     32'd9);
      checkOutput("abort_count",    32'(count),        32'd1);
      checkOutput("abort_busy",     32'(busy),         32'd0);
      checkOutput("abort_done",     32'(done_pulses),  32'd1);

      $display("[TB] abort together with start");
      setPlan(15'h0500, 15'd2, 0);
      addByte(1, 8'h77);
      addByte(5, 8'h88);
      applyStimulus(1'b0);
      checkOutput("abst_count", 32'(count), 32'd2);

      $display("[TB] randomized transfers");
      for (int n = 0; n < 30; n++) begin
         int t;
         int na;
         setPlan(15'($urandom), 15'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1);
         na = int'($urandom_range(0, 8));
         t  = int'($urandom_range(0, 3));
         for (int k = 0; k < na; k++) begin
            addByte(t, 8'($urandom));
            t = t + 1 + int'($urandom_range(0, 5));
         end
         applyStimulus($urandom_range(0, 1) == 1);
      end

      $display("[TB] reset mid-write");
      resetMidWrite();
      setPlan(15'h0600, 15'd2, -1);
      addByte(1, 8'h9A);
      addByte(2, 8'h9B);
      applyStimulus(1'b0);
      checkOutput("post_rst_count", 32'(count), 32'd2);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
